pe_seq_ctrl: RTL and testbench
==============================

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have: start  in  1  one-cycle tile start pulse; busy  out  1  high outside IDLE; done  out  1  one-cycle tile-complete pulse; err  out  1  pulses with done on bad config.
REQ-003 SHALL have: cfg_exp_bias  in  5  tile exponent bias; cfg_width  in  8  image words per row; cfg_rows  in  8  rows per tile.
REQ-004 SHALL have: wgt_req  out  1  weight fetch request; wgt_vld  in  1  weight valid; wgt_data  in  36  packed kernel word.
REQ-005 SHALL have: img_vld  in  1  image word valid; img_rdy  out  1  controller accepts word; img_data  in  24  image column word.
REQ-006 SHALL have: pe_exp_bias  out  5; pe_weight  out  36; pe_image  out  24; pe_img_en  out  1  window-buffer shift enable.
REQ-007 SHALL have: out_vld  out  1  PE result valid this cycle; out_row  out  8; out_col  out  8  output coordinates.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD_W, PRIME, RUN, DRAIN, FIN.
REQ-009 IDLE: on start, latch cfg_* into internal registers; if cfg_width<3 or cfg_rows==0 go FIN with err=1, else go LOAD_W; start outside IDLE SHALL be ignored.
REQ-010 LOAD_W: wgt_req=1 until wgt_vld; on wgt_vld capture wgt_data into pe_weight, drive latched bias on pe_exp_bias, go PRIME next cycle.
REQ-011 pe_weight and pe_exp_bias SHALL hold constant from capture until next tile's capture.
REQ-012 img_rdy SHALL be 1 only in PRIME and RUN; a word is accepted when img_vld&img_rdy.
REQ-013 On acceptance: pe_image=img_data and pe_img_en=1 for that cycle; otherwise pe_img_en=0 and pe_image holds.
REQ-014 Column counter col counts accepted words in the current row, 0..cfg_width-1; row counter counts rows 0..cfg_rows-1.
REQ-015 PRIME covers the first PRIME_CNT(=2) accepted words of each row; then state RUN.
REQ-016 RUN: each accepted word (col>=2) produces a valid window; out_vld SHALL assert exactly MAC_LAT(=1) cycle after that acceptance with out_row=row, out_col=col-2.
REQ-017 Input stalls (img_vld=0) SHALL insert bubbles only; no out_vld generated for stalled cycles, counters hold.
REQ-018 Acceptance of col==cfg_width-1: wrap col to 0; if row<cfg_rows-1 increment row and go PRIME (window re-primes every row); else go DRAIN.
REQ-019 DRAIN SHALL last MAC_LAT cycles, allowing the final out_vld, then go FIN.
REQ-020 FIN SHALL assert done=1 for one cycle, then go IDLE.
REQ-021 Outputs per valid tile SHALL equal cfg_rows*(cfg_width-2) out_vld pulses.
REQ-022 out_vld SHALL be registered; all other control outputs decoded from state/registers.

Reset
REQ-023 rst low SHALL asynchronously force state IDLE, counters 0, and all outputs 0 (pe_weight, pe_image, pe_exp_bias, out_row, out_col included).
REQ-024 Reset asserted mid-tile SHALL abort with no done pulse; operation resumes only on a new start after release.

Structure
REQ-025 Shared package SHALL hold state enum, PRIME_CNT=2, MAC_LAT=1, and widths IMG_W=24, WGT_W=36, BIAS_W=5, CNT_W=8.
REQ-026 Single sub-module pe_out_tracker SHALL hold the MAC_LAT delay line producing out_vld/out_row/out_col.

Verification
REQ-027 Reset mid-RUN -> all outputs 0 immediately, state IDLE, no done.
REQ-028 start, cfg_width=5, cfg_rows=2, img_vld=1 always, wgt_vld 3 cycles after wgt_req -> 6 out_vld, cols 0,1,2 per row, one done pulse.
REQ-029 Same config with img_vld low every other cycle -> identical 6 outputs and coordinates, counters hold across bubbles.
REQ-030 start with cfg_width=2 -> FIN next cycle, done=1 and err=1, no wgt_req, no out_vld.
REQ-031 Second start pulse during RUN -> ignored; tile completes with expected output count.
REQ-032 cfg_width=255, cfg_rows=1 -> 253 outputs, final out_col=252, done one cycle after DRAIN.

Source files
------------

// File: rtl/pe_seq_ctrl_pkg.sv
// Shared types and constants for the PE tile sequencer and its output tracker.
package pe_seq_ctrl_pkg;

    localparam int IMG_W     = 24;
    localparam int WGT_W     = 36;
    localparam int BIAS_W    = 5;
    localparam int CNT_W     = 8;
    localparam int PRIME_CNT = 2;
    localparam int MAC_LAT   = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        PRIME  = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        FIN    = 3'd5
    } state_t;

    // A tile needs at least one full window per row and at least one row.
    function automatic logic cfg_is_bad(input logic [CNT_W-1:0] width,
                                        input logic [CNT_W-1:0] rows);
        return (width < CNT_W'(PRIME_CNT + 1)) || (rows == '0);
    endfunction

endpackage

// File: rtl/pe_out_tracker.sv
// Delay line aligning result-valid and output coordinates with the MAC pipeline.
module pe_out_tracker
    import pe_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fire_i,
    input  logic [CNT_W-1:0] row_i,
    input  logic [CNT_W-1:0] col_i,
    output logic             out_vld_o,
    output logic [CNT_W-1:0] out_row_o,
    output logic [CNT_W-1:0] out_col_o
);

    logic             vld_q [MAC_LAT];
    logic [CNT_W-1:0] row_q [MAC_LAT];
    logic [CNT_W-1:0] col_q [MAC_LAT];

    // Coordinates only advance with a valid, so the outputs keep the last result's position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                vld_q[i] <= 1'b0;
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= fire_i;
            if (fire_i) begin
                row_q[0] <= row_i;
                col_q[0] <= col_i;
            end
            for (int i = 1; i < MAC_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    row_q[i] <= row_q[i-1];
                    col_q[i] <= col_q[i-1];
                end
            end
        end
    end

    assign out_vld_o = vld_q[MAC_LAT-1];
    assign out_row_o = row_q[MAC_LAT-1];
    assign out_col_o = col_q[MAC_LAT-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Tile sequencer: loads one kernel word, streams image columns into the PE window
// buffer row by row, and reports valid-window coordinates after the MAC latency.
module pe_seq_ctrl
    import pe_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [BIAS_W-1:0] cfg_exp_bias,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_rows,
    output logic              wgt_req,
    input  logic              wgt_vld,
    input  logic [WGT_W-1:0]  wgt_data,
    input  logic              img_vld,
    output logic              img_rdy,
    input  logic [IMG_W-1:0]  img_data,
    output logic [BIAS_W-1:0] pe_exp_bias,
    output logic [WGT_W-1:0]  pe_weight,
    output logic [IMG_W-1:0]  pe_image,
    output logic              pe_img_en,
    output logic              out_vld,
    output logic [CNT_W-1:0]  out_row,
    output logic [CNT_W-1:0]  out_col
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  rows_q, rows_d;
    logic [BIAS_W-1:0] bias_cfg_q, bias_cfg_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              err_q, err_d;
    logic [WGT_W-1:0]  weight_q, weight_d;
    logic [BIAS_W-1:0] pe_bias_q, pe_bias_d;
    logic [IMG_W-1:0]  image_q, image_d;

    logic              accept;
    logic              fire;
    logic [CNT_W-1:0]  fire_col;

    assign img_rdy  = (state_q == PRIME) || (state_q == RUN);
    assign accept   = img_vld && img_rdy;
    assign fire     = accept && (col_q >= CNT_W'(PRIME_CNT));
    assign fire_col = col_q - CNT_W'(PRIME_CNT);

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign err         = done && err_q;
    assign wgt_req     = (state_q == LOAD_W);
    assign pe_img_en   = accept;
    assign pe_image    = accept ? img_data : image_q;
    assign pe_weight   = weight_q;
    assign pe_exp_bias = pe_bias_q;

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        rows_d     = rows_q;
        bias_cfg_d = bias_cfg_q;
        col_d      = col_q;
        row_d      = row_q;
        drain_d    = drain_q;
        err_d      = err_q;
        weight_d   = weight_q;
        pe_bias_d  = pe_bias_q;
        image_d    = image_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    width_d    = cfg_width;
                    rows_d     = cfg_rows;
                    bias_cfg_d = cfg_exp_bias;
                    col_d      = '0;
                    row_d      = '0;
                    drain_d    = '0;
                    if (cfg_is_bad(cfg_width, cfg_rows)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
                        state_d = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (wgt_vld) begin
                    weight_d  = wgt_data;
                    pe_bias_d = bias_cfg_q;
                    state_d   = PRIME;
                end
            end
            PRIME, RUN: begin
                if (accept) begin
                    image_d = img_data;
                    if (col_q == width_q - CNT_W'(1)) begin
                        // Row end: the window buffer must re-prime before the next row.
                        col_d = '0;
                        if (row_q < rows_q - CNT_W'(1)) begin
                            row_d   = row_q + CNT_W'(1);
                            state_d = PRIME;
                        end else begin
                            drain_d = '0;
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                        if (col_q == CNT_W'(PRIME_CNT - 1)) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == CNT_W'(MAC_LAT - 1)) begin
                    state_d = FIN;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            FIN: begin
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            width_q    <= '0;
            rows_q     <= '0;
            bias_cfg_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            err_q      <= 1'b0;
            weight_q   <= '0;
            pe_bias_q  <= '0;
            image_q    <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            rows_q     <= rows_d;
            bias_cfg_q <= bias_cfg_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            weight_q   <= weight_d;
            pe_bias_q  <= pe_bias_d;
            image_q    <= image_d;
        end
    end

    pe_out_tracker u_out_tracker (
        .clk       (clk),
        .rst       (rst),
        .fire_i    (fire),
        .row_i     (row_q),
        .col_i     (fire_col),
        .out_vld_o (out_vld),
        .out_row_o (out_row),
        .out_col_o (out_col)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl: directed tiles push expected results, a
// negedge monitor pops and compares whatever the DUT presents.
module tb_pe_seq_ctrl;
    import pe_seq_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, err;
    logic [BIAS_W-1:0] cfg_exp_bias = '0;
    logic [CNT_W-1:0]  cfg_width = '0;
    logic [CNT_W-1:0]  cfg_rows = '0;
    logic              wgt_req;
    logic              wgt_vld = 1'b0;
    logic [WGT_W-1:0]  wgt_data = '0;
    logic              img_vld = 1'b0;
    logic              img_rdy;
    logic [IMG_W-1:0]  img_data = '0;
    logic [BIAS_W-1:0] pe_exp_bias;
    logic [WGT_W-1:0]  pe_weight;
    logic [IMG_W-1:0]  pe_image;
    logic              pe_img_en;
    logic              out_vld;
    logic [CNT_W-1:0]  out_row, out_col;

    pe_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .cfg_exp_bias(cfg_exp_bias), .cfg_width(cfg_width), .cfg_rows(cfg_rows),
        .wgt_req(wgt_req), .wgt_vld(wgt_vld), .wgt_data(wgt_data),
        .img_vld(img_vld), .img_rdy(img_rdy), .img_data(img_data),
        .pe_exp_bias(pe_exp_bias), .pe_weight(pe_weight), .pe_image(pe_image),
        .pe_img_en(pe_img_en), .out_vld(out_vld), .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_vld_cyc = -100;
    int wgt_req_cnt = 0;
    bit mon_en = 1'b1;

    int         exp_row_q[$];
    int         exp_col_q[$];
    logic [23:0] exp_img_q[$];
    logic       exp_err_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_wgt_req"}, wgt_req, 0);
        check({tag, "_img_rdy"}, img_rdy, 0);
        check({tag, "_pe_img_en"}, pe_img_en, 0);
        check({tag, "_pe_weight"}, pe_weight, 0);
        check({tag, "_pe_image"}, pe_image, 0);
        check({tag, "_pe_exp_bias"}, pe_exp_bias, 0);
        check({tag, "_out_vld"}, out_vld, 0);
        check({tag, "_out_row"}, out_row, 0);
        check({tag, "_out_col"}, out_col, 0);
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard heads.
    int          m_r, m_c;
    logic [23:0] m_img;
    logic        m_err;
    always @(negedge clk) begin
        if (rst) begin
            if (wgt_req) wgt_req_cnt++;
            if (mon_en && out_vld) begin
                if (exp_row_q.size() == 0) begin
                    fail_now($sformatf("unexpected_out_vld row=%0d col=%0d", out_row, out_col));
                end else begin
                    m_r = exp_row_q.pop_front();
                    m_c = exp_col_q.pop_front();
                    check("out_row", out_row, m_r);
                    check("out_col", out_col, m_c);
                end
                last_vld_cyc = cyc;
            end
            if (mon_en && pe_img_en) begin
                if (exp_img_q.size() == 0) begin
                    fail_now($sformatf("unexpected_pe_img_en image=%0h", pe_image));
                end else begin
                    m_img = exp_img_q.pop_front();
                    check("pe_image", pe_image, m_img);
                end
            end
            if (done) begin
                if (exp_err_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    m_err = exp_err_q.pop_front();
                    check("done_err", err, m_err);
                    if (!m_err) check("done_after_last_out", cyc - last_vld_cyc, 1);
                end
            end else if (err) begin
                check("err_without_done", err, 0);
            end
        end
    end

    task automatic run_tile(input int width, input int rows, input logic [4:0] bias,
                            input logic [35:0] wgt, input bit stall, input bit dup_start,
                            input logic [23:0] base);
        int total;
        int k;
        int guard;
        bit acc;
        bit ph;
        bit dup_done;
        total = width * rows;
        for (int r = 0; r < rows; r++)
            for (int c = PRIME_CNT; c < width; c++) begin
                exp_row_q.push_back(r);
                exp_col_q.push_back(c - PRIME_CNT);
            end
        for (int i = 0; i < total; i++) exp_img_q.push_back(base + 24'(i));
        exp_err_q.push_back(1'b0);

        @(posedge clk); #1;
        start = 1'b1; cfg_width = 8'(width); cfg_rows = 8'(rows); cfg_exp_bias = bias;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!wgt_req && guard < 20) begin @(posedge clk); #1; guard++; end
        if (!wgt_req) fail_now("timeout_wgt_req");
        repeat (3) @(posedge clk);
        #1;
        check("wgt_req_held", wgt_req, 1);
        wgt_vld = 1'b1; wgt_data = wgt;
        @(posedge clk); #1;
        wgt_vld = 1'b0; wgt_data = '0;
        check("pe_weight_capture", pe_weight, wgt);
        check("pe_exp_bias_capture", pe_exp_bias, bias);

        k = 0; guard = 0; ph = 1'b0; dup_done = 1'b0;
        while (k < total && guard < 4000) begin
            img_vld  = (stall && ph) ? 1'b0 : 1'b1;
            ph       = ~ph;
            img_data = base + 24'(k);
            if (dup_start && !dup_done && k == 3) begin
                start = 1'b1; cfg_width = 8'd2; cfg_rows = 8'd0; dup_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = img_vld && img_rdy;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        img_vld = 1'b0; start = 1'b0;
        if (k < total) fail_now("timeout_img_feed");
        guard = 0;
        while (!done && guard < 20) begin @(posedge clk); #1; guard++; end
        if (!done) fail_now("timeout_done");
        @(posedge clk); #1;
        check("busy_after_tile", busy, 0);
        check("outputs_left", exp_row_q.size(), 0);
        check("images_left", exp_img_q.size(), 0);
        check("done_left", exp_err_q.size(), 0);
        check("pe_weight_hold", pe_weight, wgt);
        check("pe_exp_bias_hold", pe_exp_bias, bias);
    endtask

    task automatic bad_cfg(input int width, input int rows);
        int n0;
        n0 = wgt_req_cnt;
        exp_err_q.push_back(1'b1);
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 8'(width); cfg_rows = 8'(rows);
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_cfg_done", done, 1);
        check("bad_cfg_err", err, 1);
        @(posedge clk); #1;
        check("bad_cfg_busy_after", busy, 0);
        check("bad_cfg_done_pulse", done, 0);
        check("bad_cfg_wgt_req_cycles", wgt_req_cnt - n0, 0);
        check("bad_cfg_done_left", exp_err_q.size(), 0);
    endtask

    task automatic reset_mid_run();
        int guard;
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 8'd5; cfg_rows = 8'd2; cfg_exp_bias = 5'h0a;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!wgt_req && guard < 20) begin @(posedge clk); #1; guard++; end
        wgt_vld = 1'b1; wgt_data = 36'h1_2345_6789;
        @(posedge clk); #1;
        wgt_vld = 1'b0;
        img_vld = 1'b1; img_data = 24'h00beef;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_all_zero("mid_run_reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        img_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle_busy", busy, 0);
            check("post_reset_no_done", done, 0);
        end
        exp_row_q.delete(); exp_col_q.delete(); exp_img_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        run_tile(5, 2, 5'h13, 36'h9_abcd_1234, 1'b0, 1'b0, 24'h100000);
        run_tile(5, 2, 5'h07, 36'h3_5555_aaaa, 1'b1, 1'b0, 24'h200000);
        bad_cfg(2, 3);
        bad_cfg(5, 0);
        run_tile(6, 2, 5'h1f, 36'hf_0f0f_0f0f, 1'b0, 1'b1, 24'h300000);
        run_tile(255, 1, 5'h01, 36'h0_0000_0001, 1'b0, 1'b0, 24'h400000);
        reset_mid_run();
        run_tile(5, 2, 5'h11, 36'h8_8888_7777, 1'b1, 1'b0, 24'h500000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
